load_align_unit: RTL and testbench

- Multi-cycle load stage between the data-memory port and the operand extender.
- Accepts one load command (address, size, sign flag) and issues a word read with a req/ack handshake.
- Selects the addressed byte/halfword lane and right-aligns it into a 32-bit result.
- Hands the result plus width/sign tags to the downstream extender via a valid/ready handshake.

---
 rtl/load_align_unit.sv | 148 ++++++++++++++
 tb/tb_load_align_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load stage: issues a word read, right-aligns the addressed byte/halfword lane and hands it downstream.
// Optional misalignment trap is enabled by defining LOAD_MISALIGN_TRAP_EN.
module load_align_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    input  logic              ld_sext,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [1:0]        out_size,
    output logic              out_sext,
    output logic              out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

    state_t      state_r;
    logic [1:0]  lane_r;
    logic [15:0] count_r;
    logic        trap_s;

    function automatic logic [31:0] lane_select(input logic [1:0] addr,
                                                input logic [1:0] size,
                                                input logic [31:0] word);
        logic [31:0] r;
        r = 32'd0;
        case (size)
            2'b00: begin
                case (addr)
                    2'b00:   r = {24'd0, word[7:0]};
                    2'b01:   r = {24'd0, word[15:8]};
                    2'b10:   r = {24'd0, word[23:16]};
                    2'b11:   r = {24'd0, word[31:24]};
                    default: r = 32'd0;
                endcase
            end
            2'b01:   r = addr[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] addr, input logic [1:0] size);
        logic r;
        r = 1'b0;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = addr[0];
            default: r = (addr != 2'b00);
        endcase
        return r;
    endfunction

    assign trap_s = misaligned(ld_addr[1:0], ld_size);
`else
    assign trap_s = 1'b0;
`endif

    // Load FSM; every output is registered and only changes on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            lane_r    <= 2'b00;
            count_r   <= 16'd0;
            ld_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_size  <= 2'b00;
            out_sext  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ld_valid) begin
                        lane_r   <= ld_addr[1:0];
                        out_size <= ld_size;
                        out_sext <= ld_sext;
                        mem_addr <= {ld_addr[ADDR_W-1:2], 2'b00};
                        ld_ready <= 1'b0;
                        count_r  <= 16'd0;
                        if (trap_s) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_data  <= 32'd0;
                            state_r   <= RESP;
                        end else begin
                            mem_req <= 1'b1;
                            state_r <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        out_data  <= lane_select(lane_r, out_size, mem_rdata);
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state_r   <= RESP;
                    end else if (count_r == LAST_COUNT) begin
                        // Abort: acks arriving from here on land outside REQ and are dropped.
                        out_data  <= 32'd0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state_r   <= RESP;
                    end else begin
                        count_r <= count_r + 16'd1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        ld_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req   <= 1'b0;
                    out_valid <= 1'b0;
                    ld_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: expected results queued at command drive, checked at output handshake.
module tb_load_align_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr = 32'd0;
    logic [1:0]        ld_size = 2'b00;
    logic              ld_sext = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_rdata = 32'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_data;
    logic [1:0]        out_size;
    logic              out_sext;
    logic              out_err;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  size;
        logic        sext;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    load_align_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_sext(ld_sext),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_size(out_size), .out_sext(out_sext), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // waits < 0 means never ack; hold is the number of cycles out_ready stays low in RESP
    task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic sext, input logic [31:0] rdata, input int waits,
                            input int hold, input logic [31:0] exp_data, input logic exp_err,
                            input int exp_lat, input int exp_req);
        exp_t e;
        int   lat;
        int   req_cycles;
        logic seen;
        @(negedge clk);
        check_eq({name, "_ld_ready"}, ld_ready, 32'd1);
        ld_valid = 1'b1; ld_addr = addr; ld_size = size; ld_sext = sext; mem_ack = 1'b0;
        sb.push_back('{exp_data, size, sext, exp_err});
        lat = 0; req_cycles = 0; seen = 1'b0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clk);
            ld_valid = 1'b0; mem_ack = 1'b0; lat++;
            if (out_valid) begin
                seen = 1'b1;
            end else if (mem_req) begin
                if (req_cycles == 0) check_eq({name, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
                check_eq({name, "_ld_ready_req"}, ld_ready, 32'd0);
                if (waits >= 0 && req_cycles == waits) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end
                req_cycles++;
            end
        end
        check_eq({name, "_out_valid_seen"}, seen, 32'd1);
        check_eq({name, "_latency"}, lat, exp_lat);
        check_eq({name, "_req_cycles"}, req_cycles, exp_req);
        // Stray ack and a competing command while the result is pending
        mem_ack = 1'b1; mem_rdata = ~rdata;
        for (int h = 0; h < hold; h++) begin
            ld_valid = 1'b1; ld_addr = 32'h0000_0ABC; ld_size = 2'b10;
            @(negedge clk);
            check_eq({name, "_hold_valid"}, out_valid, 32'd1);
            check_eq({name, "_hold_data"}, out_data, exp_data);
            check_eq({name, "_hold_ld_ready"}, ld_ready, 32'd0);
            check_eq({name, "_hold_mem_req"}, mem_req, 32'd0);
        end
        check_eq({name, "_sb_depth"}, sb.size(), 32'd1);
        e = sb.pop_front();
        check_eq({name, "_out_valid"}, out_valid, 32'd1);
        check_eq({name, "_out_data"}, out_data, e.data);
        check_eq({name, "_out_size"}, out_size, {30'd0, e.size});
        check_eq({name, "_out_sext"}, out_sext, {31'd0, e.sext});
        check_eq({name, "_out_err"}, out_err, {31'd0, e.err});
        out_ready = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({name, "_post_valid"}, out_valid, 32'd0);
        check_eq({name, "_post_err"}, out_err, 32'd0);
        check_eq({name, "_post_ld_ready"}, ld_ready, 32'd1);
        check_eq({name, "_post_mem_req"}, mem_req, 32'd0);
        ld_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ld_ready", ld_ready, 32'd1);
        check_eq("rst_mem_req", mem_req, 32'd0);
        check_eq("rst_out_valid", out_valid, 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_err", out_err, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        run_load("b0", 32'h1000, 2'b00, 1'b0, 32'h8877_6655, 0, 0, 32'h55, 1'b0, 2, 1);
        run_load("b1", 32'h1001, 2'b00, 1'b0, 32'h8877_6655, 0, 0, 32'h66, 1'b0, 2, 1);
        run_load("b2", 32'h1002, 2'b00, 1'b1, 32'h8877_6655, 0, 0, 32'h77, 1'b0, 2, 1);
        run_load("b3", 32'h1003, 2'b00, 1'b0, 32'h8877_6655, 0, 0, 32'h88, 1'b0, 2, 1);
        run_load("h_hi", 32'h2002, 2'b01, 1'b1, 32'hF00D_1234, 3, 0, 32'h0000_F00D, 1'b0, 5, 4);
        run_load("h_lo", 32'h2000, 2'b01, 1'b0, 32'hF00D_1234, 1, 0, 32'h0000_1234, 1'b0, 3, 2);
        run_load("w_hold", 32'h4000, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 1'b0, 2, 1);
        run_load("w_rsv", 32'h6000, 2'b11, 1'b1, 32'hCAFE_F00D, 2, 0, 32'hCAFE_F00D, 1'b0, 4, 3);
        run_load("tmo", 32'h7004, 2'b10, 1'b0, 32'h1234_5678, -1, 2, 32'h0, 1'b1, TIMEOUT + 1, TIMEOUT);
`ifdef LOAD_MISALIGN_TRAP_EN
        run_load("mis_w", 32'h3001, 2'b10, 1'b0, 32'hA5A5_5A5A, 0, 0, 32'h0, 1'b1, 1, 0);
        run_load("mis_h", 32'h2001, 2'b01, 1'b0, 32'hF00D_1234, 0, 0, 32'h0, 1'b1, 1, 0);
`else
        run_load("mis_w", 32'h3001, 2'b10, 1'b0, 32'hA5A5_5A5A, 0, 0, 32'hA5A5_5A5A, 1'b0, 2, 1);
        run_load("mis_h", 32'h2001, 2'b01, 1'b0, 32'hF00D_1234, 0, 0, 32'h0000_1234, 1'b0, 2, 1);
`endif

        // Asynchronous reset while the read is outstanding
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h5000; ld_size = 2'b10; ld_sext = 1'b0;
        @(negedge clk);
        ld_valid = 1'b0;
        check_eq("arst_pre_mem_req", mem_req, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", mem_req, 32'd0);
        check_eq("arst_out_valid", out_valid, 32'd0);
        check_eq("arst_ld_ready", ld_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_load("arst_fresh", 32'h5001, 2'b00, 1'b0, 32'h1122_3344, 0, 0, 32'h33, 1'b0, 2, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
